// File: rtl/clear_engine.sv
// clear_engine: fills the latched viewport with the latched colour, one pixel per write handshake.
// Optional: define CLEAR_ENGINE_STALL_CNT_EN to add the stall_cycles counter output.
module clear_engine #(
    parameter int FB_WIDTH  = 640,
    parameter int FB_HEIGHT = 480,
    parameter int ADDR_W    = 19,
    parameter int PIXEL_W   = 24
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear_start,
    output logic               clear_done,
    output logic               busy,
    input  logic [PIXEL_W-1:0] clear_color,
    input  logic [15:0]        vp_x_min,
    input  logic [15:0]        vp_y_min,
    input  logic [15:0]        vp_x_max,
    input  logic [15:0]        vp_y_max,
    output logic               fb_wr_valid,
    input  logic               fb_wr_ready,
    output logic [ADDR_W-1:0]  fb_wr_addr,
    output logic [PIXEL_W-1:0] fb_wr_data
`ifdef CLEAR_ENGINE_STALL_CNT_EN
    ,
    output logic [31:0]        stall_cycles
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [15:0]       X_LIM = 16'(FB_WIDTH - 1);
    localparam logic [15:0]       Y_LIM = 16'(FB_HEIGHT - 1);
    localparam logic [ADDR_W-1:0] FBW_A = ADDR_W'(FB_WIDTH);

    state_t              state_q, state_d;
    logic [PIXEL_W-1:0]  color_q, color_d;
    logic [15:0]         x_min_q, x_min_d;
    logic [15:0]         y_min_q, y_min_d;
    logic [15:0]         x_max_q, x_max_d;
    logic [15:0]         y_max_q, y_max_d;
    logic [15:0]         x_q, x_d;
    logic [15:0]         y_q, y_d;
    logic [ADDR_W-1:0]   row_base_q, row_base_d;
    logic [15:0]         x_clamp;
    logic [15:0]         y_clamp;
    logic                empty;

    assign x_clamp = (x_max_q > X_LIM) ? X_LIM : x_max_q;
    assign y_clamp = (y_max_q > Y_LIM) ? Y_LIM : y_max_q;
    assign empty   = (x_min_q > x_clamp) || (y_min_q > y_clamp) ||
                     (x_min_q > X_LIM)   || (y_min_q > Y_LIM);

    assign fb_wr_valid = (state_q == RUN);
    assign busy        = (state_q != IDLE);
    assign clear_done  = (state_q == DONE);
    assign fb_wr_addr  = fb_wr_valid ? (row_base_q + ADDR_W'(x_q)) : '0;
    assign fb_wr_data  = fb_wr_valid ? color_q : '0;

    // Next-state and raster-walk logic; row_base accumulates instead of multiplying per pixel.
    always_comb begin
        state_d    = state_q;
        color_d    = color_q;
        x_min_d    = x_min_q;
        y_min_d    = y_min_q;
        x_max_d    = x_max_q;
        y_max_d    = y_max_q;
        x_d        = x_q;
        y_d        = y_q;
        row_base_d = row_base_q;
        unique case (state_q)
            IDLE: begin
                if (clear_start) begin
                    color_d = clear_color;
                    x_min_d = vp_x_min;
                    y_min_d = vp_y_min;
                    x_max_d = vp_x_max;
                    y_max_d = vp_y_max;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                x_max_d = x_clamp;
                y_max_d = y_clamp;
                if (empty) begin
                    state_d = DONE;
                end else begin
                    x_d        = x_min_q;
                    y_d        = y_min_q;
                    row_base_d = ADDR_W'(y_min_q) * FBW_A;
                    state_d    = RUN;
                end
            end
            RUN: begin
                if (fb_wr_ready) begin
                    if (x_q == x_max_q) begin
                        if (y_q == y_max_q) begin
                            state_d = DONE;
                        end else begin
                            x_d        = x_min_q;
                            y_d        = y_q + 16'd1;
                            row_base_d = row_base_q + FBW_A;
                        end
                    end else begin
                        x_d = x_q + 16'd1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            color_q    <= '0;
            x_min_q    <= '0;
            y_min_q    <= '0;
            x_max_q    <= '0;
            y_max_q    <= '0;
            x_q        <= '0;
            y_q        <= '0;
            row_base_q <= '0;
        end else begin
            state_q    <= state_d;
            color_q    <= color_d;
            x_min_q    <= x_min_d;
            y_min_q    <= y_min_d;
            x_max_q    <= x_max_d;
            y_max_q    <= y_max_d;
            x_q        <= x_d;
            y_q        <= y_d;
            row_base_q <= row_base_d;
        end
    end

`ifdef CLEAR_ENGINE_STALL_CNT_EN
    logic [31:0] stall_q, stall_d;

    assign stall_cycles = stall_q;

    // Saturating count of back-pressured cycles, restarted by each accepted start.
    always_comb begin
        stall_d = stall_q;
        if (state_q == IDLE && clear_start) begin
            stall_d = '0;
        end else if (fb_wr_valid && !fb_wr_ready && stall_q != 32'hFFFF_FFFF) begin
            stall_d = stall_q + 32'd1;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end
`endif

endmodule

// File: tb/tb_clear_engine.sv
// tb_clear_engine: directed checks of clear_engine on an 8x4 framebuffer.
// Covers raster order, clamping, empty regions, back-pressure, ignored restarts and reset.
module tb_clear_engine;

    logic        clk;
    logic        rst;
    logic        clear_start;
    logic        clear_done;
    logic        busy;
    logic [23:0] clear_color;
    logic [15:0] vp_x_min;
    logic [15:0] vp_y_min;
    logic [15:0] vp_x_max;
    logic [15:0] vp_y_max;
    logic        fb_wr_valid;
    logic        fb_wr_ready;
    logic [4:0]  fb_wr_addr;
    logic [23:0] fb_wr_data;
`ifdef CLEAR_ENGINE_STALL_CNT_EN
    logic [31:0] stall_cycles;
`endif

    int checks = 0;
    int errors = 0;

    int waddr[$];
    int wdata[$];
    int done_cyc;
    int ndone;
    int nstall;
    int hold_bad;
    int busy1;
    int post_valid;
    int post_busy;

    clear_engine #(
        .FB_WIDTH (8),
        .FB_HEIGHT(4),
        .ADDR_W   (5),
        .PIXEL_W  (24)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .clear_start (clear_start),
        .clear_done  (clear_done),
        .busy        (busy),
        .clear_color (clear_color),
        .vp_x_min    (vp_x_min),
        .vp_y_min    (vp_y_min),
        .vp_x_max    (vp_x_max),
        .vp_y_max    (vp_y_max),
        .fb_wr_valid (fb_wr_valid),
        .fb_wr_ready (fb_wr_ready),
        .fb_wr_addr  (fb_wr_addr),
        .fb_wr_data  (fb_wr_data)
`ifdef CLEAR_ENGINE_STALL_CNT_EN
        ,
        .stall_cycles(stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse clear_start for one edge; returns just after that edge (cycle T+1).
    task automatic start(input logic [23:0] col, input int xmn, input int ymn,
                         input int xmx, input int ymx);
        clear_color = col;
        vp_x_min    = 16'(xmn);
        vp_y_min    = 16'(ymn);
        vp_x_max    = 16'(xmx);
        vp_y_max    = 16'(ymx);
        clear_start = 1'b1;
        @(posedge clk);
        #1;
        clear_start = 1'b0;
    endtask

    // Drive ready/injections per cycle and record what the DUT does for budget cycles.
    // rmode 0: ready high; 1: ready pattern 1,0,0,1 indexed by k%4.
    task automatic run(input int rmode, input int budget, input int chg_k, input int rst_w);
        logic [4:0]  pa;
        logic [23:0] pd;
        bit          pend;
        int          rst_k;
        waddr.delete();
        wdata.delete();
        done_cyc   = -1;
        ndone      = 0;
        nstall     = 0;
        hold_bad   = 0;
        busy1      = -1;
        post_valid = -1;
        post_busy  = -1;
        pend       = 0;
        rst_k      = -1;
        pa         = '0;
        pd         = '0;
        for (int k = 1; k <= budget; k++) begin
            if (rmode == 0) begin
                fb_wr_ready = 1'b1;
            end else begin
                fb_wr_ready = (k % 4 == 0) || (k % 4 == 3);
            end
            clear_start = (k == chg_k);
            if (k == chg_k) begin
                clear_color = 24'h00FF00;
                vp_x_min    = 16'd1;
                vp_y_min    = 16'd1;
                vp_x_max    = 16'd2;
                vp_y_max    = 16'd2;
            end
            rst = 1'b0;
            if (rst_w >= 0 && rst_k < 0 && waddr.size() == rst_w) begin
                rst         = 1'b1;
                rst_k       = k;
                fb_wr_ready = 1'b0;
            end
            @(negedge clk);
            if (k == 1) busy1 = int'(busy);
            if (rst_k > 0 && k == rst_k + 1) begin
                post_valid = int'(fb_wr_valid);
                post_busy  = int'(busy);
            end
            if (pend) begin
                if (!fb_wr_valid || fb_wr_addr !== pa || fb_wr_data !== pd)
                    hold_bad++;
            end
            pend = fb_wr_valid && !fb_wr_ready && !rst;
            pa   = fb_wr_addr;
            pd   = fb_wr_data;
            if (fb_wr_valid && !fb_wr_ready) nstall++;
            if (fb_wr_valid && fb_wr_ready && !rst) begin
                waddr.push_back(int'(fb_wr_addr));
                wdata.push_back(int'(fb_wr_data));
            end
            if (clear_done) begin
                ndone++;
                if (done_cyc < 0) done_cyc = k;
            end
            @(posedge clk);
            #1;
        end
        clear_start = 1'b0;
        rst         = 1'b0;
        fb_wr_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst         = 1'b1;
        clear_start = 1'b0;
        fb_wr_ready = 1'b1;
        clear_color = 24'hABCDEF;
        vp_x_min    = 16'd0;
        vp_y_min    = 16'd0;
        vp_x_max    = 16'd0;
        vp_y_max    = 16'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({clear_done, busy, fb_wr_valid} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 000", {clear_done, busy, fb_wr_valid});
        end
        checks++;
        if (fb_wr_addr !== 5'd0 || fb_wr_data !== 24'd0) begin
            errors++;
            $display("FAIL reset_bus: got addr %0d data %h want 0 0", fb_wr_addr, fb_wr_data);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_full();
        start(24'hFF0000, 0, 0, 7, 3);
        run(0, 45, 0, -1);
        checks++;
        if (busy1 !== 1) begin
            errors++;
            $display("FAIL full_busy_setup: got %0d want 1", busy1);
        end
        checks++;
        if (waddr.size() != 32) begin
            errors++;
            $display("FAIL full_count: got %0d want 32", waddr.size());
        end
        for (int i = 0; i < waddr.size() && i < 32; i++) begin
            checks++;
            if (waddr[i] != i || wdata[i] != 24'hFF0000) begin
                errors++;
                $display("FAIL full_pix%0d: got %0d/%h want %0d/ff0000", i, waddr[i], wdata[i], i);
            end
        end
        checks++;
        if (done_cyc != 34 || ndone != 1) begin
            errors++;
            $display("FAIL full_done: got cyc %0d n %0d want 34 1", done_cyc, ndone);
        end
    endtask

    task automatic test_sub();
        int exp_a[6] = '{10, 11, 12, 18, 19, 20};
        start(24'h123456, 2, 1, 4, 2);
        run(0, 20, 0, -1);
        checks++;
        if (waddr.size() != 6) begin
            errors++;
            $display("FAIL sub_count: got %0d want 6", waddr.size());
        end
        for (int i = 0; i < waddr.size() && i < 6; i++) begin
            checks++;
            if (waddr[i] != exp_a[i] || wdata[i] != 24'h123456) begin
                errors++;
                $display("FAIL sub_pix%0d: got %0d/%h want %0d/123456", i, waddr[i], wdata[i], exp_a[i]);
            end
        end
        checks++;
        if (done_cyc != 8 || ndone != 1) begin
            errors++;
            $display("FAIL sub_done: got cyc %0d n %0d want 8 1", done_cyc, ndone);
        end
    endtask

    task automatic test_stall();
        int exp_a[6] = '{10, 11, 12, 18, 19, 20};
        start(24'h0000AA, 2, 1, 4, 2);
        run(1, 25, 0, -1);
        checks++;
        if (waddr.size() != 6) begin
            errors++;
            $display("FAIL stall_count: got %0d want 6", waddr.size());
        end
        for (int i = 0; i < waddr.size() && i < 6; i++) begin
            checks++;
            if (waddr[i] != exp_a[i] || wdata[i] != 24'h0000AA) begin
                errors++;
                $display("FAIL stall_pix%0d: got %0d/%h want %0d/0000aa", i, waddr[i], wdata[i], exp_a[i]);
            end
        end
        checks++;
        if (hold_bad != 0) begin
            errors++;
            $display("FAIL stall_hold: got %0d unstable cycles want 0", hold_bad);
        end
        checks++;
        if (nstall != 5 || done_cyc != 13 || ndone != 1) begin
            errors++;
            $display("FAIL stall_timing: got stalls %0d done %0d n %0d want 5 13 1", nstall, done_cyc, ndone);
        end
`ifdef CLEAR_ENGINE_STALL_CNT_EN
        checks++;
        if (stall_cycles !== 32'd5) begin
            errors++;
            $display("FAIL stall_cnt: got %0d want 5", stall_cycles);
        end
`endif
    endtask

    task automatic test_empty_clamp();
        int exp_a[4] = '{22, 23, 30, 31};
        start(24'h111111, 5, 0, 3, 3);
        run(0, 10, 0, -1);
        checks++;
        if (waddr.size() != 0 || done_cyc != 2 || ndone != 1) begin
            errors++;
            $display("FAIL empty: got writes %0d done %0d n %0d want 0 2 1", waddr.size(), done_cyc, ndone);
        end
        start(24'h222222, 6, 2, 100, 100);
        run(0, 15, 0, -1);
        checks++;
        if (waddr.size() != 4 || done_cyc != 6) begin
            errors++;
            $display("FAIL clamp_count: got %0d done %0d want 4 6", waddr.size(), done_cyc);
        end
        for (int i = 0; i < waddr.size() && i < 4; i++) begin
            checks++;
            if (waddr[i] != exp_a[i] || wdata[i] != 24'h222222) begin
                errors++;
                $display("FAIL clamp_pix%0d: got %0d/%h want %0d/222222", i, waddr[i], wdata[i], exp_a[i]);
            end
        end
    endtask

    task automatic test_restart_ignored();
        start(24'hFF0000, 0, 0, 7, 3);
        run(0, 45, 10, -1);
        checks++;
        if (waddr.size() != 32 || ndone != 1 || done_cyc != 34) begin
            errors++;
            $display("FAIL restart: got writes %0d n %0d done %0d want 32 1 34", waddr.size(), ndone, done_cyc);
        end
        for (int i = 0; i < waddr.size() && i < 32; i++) begin
            checks++;
            if (waddr[i] != i || wdata[i] != 24'hFF0000) begin
                errors++;
                $display("FAIL restart_pix%0d: got %0d/%h want %0d/ff0000", i, waddr[i], wdata[i], i);
            end
        end
    endtask

    task automatic test_mid_reset();
        start(24'h445566, 0, 0, 7, 3);
        run(0, 20, 0, 5);
        checks++;
        if (post_valid != 0 || post_busy != 0) begin
            errors++;
            $display("FAIL rst_outputs: got valid %0d busy %0d want 0 0", post_valid, post_busy);
        end
        checks++;
        if (waddr.size() != 5 || ndone != 0) begin
            errors++;
            $display("FAIL rst_abort: got writes %0d done %0d want 5 0", waddr.size(), ndone);
        end
        start(24'h778899, 0, 0, 7, 3);
        run(0, 45, 0, -1);
        checks++;
        if (waddr.size() != 32 || ndone != 1 || done_cyc != 34) begin
            errors++;
            $display("FAIL rst_rerun: got writes %0d n %0d done %0d want 32 1 34", waddr.size(), ndone, done_cyc);
        end
        checks++;
        if (waddr.size() == 32 && (waddr[31] != 31 || wdata[31] != 24'h778899)) begin
            errors++;
            $display("FAIL rst_rerun_last: got %0d/%h want 31/778899", waddr[31], wdata[31]);
        end
    endtask

    initial begin
        test_reset();
        test_full();
        test_sub();
        test_stall();
        test_empty_clamp();
        test_restart_ignored();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/clear_engine.md
# clear_engine

Framebuffer clear unit sitting directly downstream of `command_processor`. A one-cycle `clear_start` pulse (issued on a CLEAR command) causes it to fill the current viewport rectangle with the current clear colour, one pixel per write handshake on the framebuffer write port. When the last pixel is accepted it returns a one-cycle `clear_done` pulse. Colour and viewport come from the SET_COLOR / SET_VIEWPORT state registers.

## Interface
- `FB_WIDTH`, 640, framebuffer width in pixels
- `FB_HEIGHT`, 480, framebuffer height in pixels
- `ADDR_W`, 19, framebuffer word-address width; must hold `FB_WIDTH*FB_HEIGHT-1`
- `PIXEL_W`, 24, pixel/colour width
- `clk`  input  1  clock; the only clock
- `rst`  input  1  synchronous, active-high reset
- `clear_start`  input  1  one-cycle start pulse
- `clear_done`  output  1  one-cycle completion pulse
- `busy`  output  1  high while not IDLE
- `clear_color`  input  PIXEL_W  fill colour, latched at start
- `vp_x_min`, `vp_y_min`, `vp_x_max`, `vp_y_max`  input  16 each  inclusive viewport bounds, latched at start
- `fb_wr_valid`  output  1  write request
- `fb_wr_ready`  input  1  framebuffer accepts write
- `fb_wr_addr`  output  ADDR_W  pixel address, y*FB_WIDTH + x
- `fb_wr_data`  output  PIXEL_W  pixel value

## Operation
- States: IDLE, SETUP, RUN, DONE.
- IDLE: on `clear_start`, latch colour and bounds, then go to SETUP. `clear_start` is ignored in any other state.
- SETUP:
  - Clamp: `x_max = min(vp_x_max, FB_WIDTH-1)` and `y_max = min(vp_y_max, FB_HEIGHT-1)`.
  - The region is empty if `x_min > x_max`, `y_min > y_max`, `x_min >= FB_WIDTH` or `y_min >= FB_HEIGHT`. Empty goes to DONE.
  - Otherwise set `x = x_min`, `y = y_min`, `row_base = y_min*FB_WIDTH`, and go to RUN.
- RUN:
  - `fb_wr_valid = 1`, `fb_wr_addr = row_base + x`, `fb_wr_data` = latched colour.
  - On handshake (`valid && ready`): if `x == x_max` then `x = x_min`, `y++`, `row_base += FB_WIDTH`; else `x++`.
  - The handshake at `x == x_max && y == y_max` goes to DONE.
  - No multiplier is used in RUN; `row_base` is accumulated.
- DONE: `clear_done = 1` for exactly one cycle, then IDLE.
- Raster order is row-major, ascending x then ascending y. Each pixel is written exactly once.
- Arithmetic: counters are 16-bit. The address sum is computed at ADDR_W bits and never wraps for legal parameters.

## Timing
- Reset values:
  - `clear_done = 0`, `busy = 0`, `fb_wr_valid = 0`.
  - `fb_wr_addr = 0`, `fb_wr_data = 0`, state IDLE.
- `clear_start` is sampled at edge T. SETUP occupies cycle T+1. The first `fb_wr_valid` is in cycle T+2.
- With `fb_wr_ready` held high, N pixels take cycles T+2..T+N+1 and `clear_done` is high in cycle T+N+2.
- Empty region: `clear_done` is high in cycle T+2 with no writes.
- Handshake rule: while `fb_wr_valid && !fb_wr_ready`, `fb_wr_addr`/`fb_wr_data` hold stable and valid stays high. Valid never drops before acceptance.
- `busy` is high from cycle T+1 through the DONE cycle inclusive.
- Input changes on colour or viewport after T do not affect the clear in progress.
- `rst` mid-operation: the next edge returns to IDLE with all outputs at reset values. No `clear_done` is issued and no write is left pending.

## Configuration
- `CLEAR_ENGINE_STALL_CNT_EN` defined: adds output `stall_cycles [31:0]`.
  - Counts cycles with `fb_wr_valid && !fb_wr_ready`.
  - Cleared at each accepted `clear_start`; holds its value after DONE.
  - Saturates at 0xFFFFFFFF.
  - Reset value 0.
- Undefined: the port and counter do not exist. All other behaviour is identical.

## Test plan
- FB 8x4, viewport (0,0)-(7,3), colour 0xFF0000, ready=1 -> 32 writes, addresses 0..31 in order, all data 0xFF0000; `clear_done` exactly 34 cycles after the start edge.
- FB 8x4, viewport (2,1)-(4,2) -> addresses 10,11,12,18,19,20, then one `clear_done` pulse.
- Same viewport, ready toggling 1,0,0,1,… -> identical address sequence; addr/data stable during stalls; with STALL_CNT_EN, `stall_cycles` equals the stalled-cycle count.
- Viewport (5,0)-(3,3) -> zero writes, `clear_done` at T+2. Viewport (6,2)-(100,100) -> clamps to addresses 22,23,30,31.
- `clear_start` pulsed mid-RUN and colour changed mid-RUN -> ignored; original colour throughout; single `clear_done`.
- `rst` asserted after 5 of 32 writes -> `fb_wr_valid=0` and `busy=0` next cycle, no `clear_done`; a new start then completes all 32 writes.
